// File: rtl/bp_btb_bimodal.sv
// bp_btb_bimodal: direct-mapped BTB with per-entry saturating direction counters.
module bp_btb_bimodal #(
  parameter int AWIDTH       = 32,
  parameter int ENTRIES      = 64,
  parameter int COUNTER_BITS = 2,
  parameter int PERF_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AWIDTH-1:0]     lookup_pc,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [AWIDTH-1:0]     pred_target,
  input  logic                  update_valid,
  input  logic [AWIDTH-1:0]     update_pc,
  input  logic                  update_taken,
  input  logic [AWIDTH-1:0]     update_target,
  input  logic                  update_mispredict,
  output logic [PERF_WIDTH-1:0] branch_count,
  output logic [PERF_WIDTH-1:0] mispredict_count
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = AWIDTH - IDX - 2;
  localparam logic [COUNTER_BITS-1:0] C_MAX = '1;
  localparam logic [COUNTER_BITS-1:0] C_WT  = COUNTER_BITS'(1 << (COUNTER_BITS - 1));
  localparam logic [COUNTER_BITS-1:0] C_WNT = COUNTER_BITS'((1 << (COUNTER_BITS - 1)) - 1);

  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0 || COUNTER_BITS < 1 || COUNTER_BITS > 4) begin : g_bad_params
    $error("bp_btb_bimodal: ENTRIES must be a power of two >= 2 and COUNTER_BITS in 1..4");
  end

  logic                    r_valid  [ENTRIES];
  logic [TW-1:0]           r_tag    [ENTRIES];
  logic [AWIDTH-1:0]       r_target [ENTRIES];
  logic [COUNTER_BITS-1:0] r_cnt    [ENTRIES];

  logic [IDX-1:0]          w_li, w_ui;
  logic [TW-1:0]           w_lt, w_ut;
  logic                    w_uhit;
  logic [COUNTER_BITS-1:0] w_ucnt;
  logic                    w_unused;

  assign w_li     = lookup_pc[IDX+1:2];
  assign w_lt     = lookup_pc[AWIDTH-1:IDX+2];
  assign w_ui     = update_pc[IDX+1:2];
  assign w_ut     = update_pc[AWIDTH-1:IDX+2];
  assign w_unused = ^update_pc[1:0];

  always_comb begin
    pred_hit    = r_valid[w_li] && (r_tag[w_li] == w_lt);
    pred_taken  = pred_hit && r_cnt[w_li][COUNTER_BITS-1];
    pred_target = pred_taken ? r_target[w_li] : lookup_pc + AWIDTH'(4);
    w_uhit      = r_valid[w_ui] && (r_tag[w_ui] == w_ut);
    w_ucnt      = r_cnt[w_ui];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= C_WNT;
      end
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (update_valid) begin
      if (w_uhit)
        r_cnt[w_ui] <= update_taken ? ((w_ucnt == C_MAX) ? w_ucnt : w_ucnt + COUNTER_BITS'(1))
                                    : ((w_ucnt == '0) ? w_ucnt : w_ucnt - COUNTER_BITS'(1));
      else if (update_taken) begin
        r_valid[w_ui] <= 1'b1;
        r_cnt[w_ui]   <= C_WT;
      end
      if (!(&branch_count))
        branch_count <= branch_count + PERF_WIDTH'(1);
      if (update_mispredict && !(&mispredict_count))
        mispredict_count <= mispredict_count + PERF_WIDTH'(1);
    end
  end

  // Tags and targets need no reset: they are only observed through a valid entry.
  always_ff @(posedge clk) begin
    if (!reset && update_valid && update_taken) begin
      r_target[w_ui] <= update_target;
      if (!w_uhit)
        r_tag[w_ui] <= w_ut;
    end
  end
endmodule

// File: tb/tb_bp_btb_bimodal.sv
// tb_bp_btb_bimodal: scoreboard bench for bp_btb_bimodal against an array-based reference model.
module tb_bp_btb_bimodal;
  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] bc;
    logic [31:0] mc;
    logic [3:0]  bc4;
    logic [3:0]  mc4;
  } exp_t;

  logic        clk = 1'b0, reset = 1'b1, chk = 1'b0;
  logic [31:0] lookup_pc = '0, update_pc = '0, update_target = '0;
  logic        update_valid = 1'b0, update_taken = 1'b0, update_mispredict = 1'b0;
  logic        pred_hit, pred_taken, pred_hit4, pred_taken4;
  logic [31:0] pred_target, pred_target4, branch_count, mispredict_count;
  logic [3:0]  branch_count4, mispredict_count4;

  int checks = 0, failures = 0;
  exp_t q[$];

  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_cnt   [64];
  longint      m_bc, m_mc;

  bp_btb_bimodal dut (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  bp_btb_bimodal #(.PERF_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit4), .pred_taken(pred_taken4), .pred_target(pred_target4),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .branch_count(branch_count4), .mispredict_count(mispredict_count4)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_cnt[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s pc=%h got=%h expected=%h", name, lookup_pc, act, exp);
    end
  endtask

  // One cycle: drive, record the expectation from the model's pre-update state, then apply the update.
  task automatic cycle(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utg, input logic um, input logic rst);
    exp_t e;
    int li, ui;
    bit uh;
    @(posedge clk);
    #1;
    lookup_pc = lpc; update_valid = uv; update_pc = upc; update_taken = ut;
    update_target = utg; update_mispredict = um; reset = rst; chk = 1'b1;
    li      = int'(lpc[7:2]);
    e.hit   = m_valid[li] && m_tag[li] == {8'h0, lpc[31:8]};
    e.taken = e.hit && m_cnt[li] >= 2;
    e.tgt   = e.taken ? m_tgt[li] : lpc + 32'd4;
    e.bc    = 32'(m_bc);
    e.mc    = 32'(m_mc);
    e.bc4   = 4'(m_bc > 15 ? 15 : m_bc);
    e.mc4   = 4'(m_mc > 15 ? 15 : m_mc);
    q.push_back(e);
    if (rst) model_reset();
    else if (uv) begin
      ui = int'(upc[7:2]);
      uh = m_valid[ui] && m_tag[ui] == {8'h0, upc[31:8]};
      if (uh && ut) begin
        m_cnt[ui] = m_cnt[ui] == 3 ? 3 : m_cnt[ui] + 1;
        m_tgt[ui] = utg;
      end else if (uh) m_cnt[ui] = m_cnt[ui] == 0 ? 0 : m_cnt[ui] - 1;
      else if (ut) begin
        m_valid[ui] = 1; m_tag[ui] = {8'h0, upc[31:8]}; m_tgt[ui] = utg; m_cnt[ui] = 2;
      end
      if (m_bc < 64'hFFFF_FFFF) m_bc++;
      if (um && m_mc < 64'hFFFF_FFFF) m_mc++;
    end
  endtask

  task automatic look(input logic [31:0] pc);
    cycle(pc, 0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tg, input logic m);
    cycle(pc, 1, pc, t, tg, m, 0);
  endtask

  always @(negedge clk) begin
    if (chk) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow got=empty expected=entry");
      end else begin
        exp_t e;
        e = q.pop_front();
        cmp("pred_hit", 32'(pred_hit), 32'(e.hit));
        cmp("pred_taken", 32'(pred_taken), 32'(e.taken));
        cmp("pred_target", pred_target, e.tgt);
        cmp("branch_count", branch_count, e.bc);
        cmp("mispredict_count", mispredict_count, e.mc);
        cmp("branch_count_w4", 32'(branch_count4), 32'(e.bc4));
        cmp("mispredict_count_w4", 32'(mispredict_count4), 32'(e.mc4));
      end
    end
  end

  localparam logic [31:0] A = 32'h0100_0010;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    for (int i = 0; i < 64; i++) look(32'h0100_0000 + 32'(i * 4));
    upd(A, 1, 32'h0100_0040, 0);
    look(A);
    repeat (2) upd(A, 0, 32'h0, 0);
    look(A);
    repeat (5) upd(A, 1, 32'h0100_0040, 1);
    look(A);
    upd(A, 0, 32'h0, 0);
    look(A);
    upd(A, 1, 32'h0200_0000, 0);
    upd(A + 32'h100, 1, 32'h0300_0000, 0);
    look(A);
    look(A + 32'h100);
    upd(32'h0100_0030, 0, 32'h0, 0);
    look(32'h0100_0030);
    cycle(32'h0100_0020, 1, 32'h0100_0020, 1, 32'h0400_0000, 0, 0);
    look(32'h0100_0020);
    look(32'hFFFF_FFFC);
    cycle(A, 1, A, 1, 32'h0500_0000, 1, 1);
    for (int i = 0; i < 64; i++) look(32'h0100_0000 + 32'(i * 4));
    for (int i = 0; i < 10; i++) upd(32'h0100_0000 + 32'(i * 4), i[0], 32'h0600_0000 + 32'(i), i < 3);
    look(32'h0100_0004);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] lpc, upc;
      lpc = 32'h0100_0000 | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3) << 8) | 32'($urandom_range(0, 3));
      upc = 32'h0100_0000 | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3) << 8) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) lpc = 32'hFFFF_FFFC;
      cycle(lpc, 1'($urandom_range(0, 3) != 0), upc, 1'($urandom), $urandom, 1'($urandom),
            $urandom_range(0, 149) == 0);
    end
    @(posedge clk);
    #1;
    chk = 1'b0;
    update_valid = 1'b0;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
